// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the registered ALU.
//   - WIDTH            datapath width (32)
//   - FLAG_O/S/C/Z     bit positions of the flags in the packed flag vector
//   - opcode localparams, one per operation
// Optional feature macro: ALU_SHIFT_EN (see alu.sv).
package alu_pkg;

   localparam int unsigned WIDTH = 32;

   localparam int unsigned FLAG_O = 3;
   localparam int unsigned FLAG_S = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_Z = 0;

   // Arithmetic
   localparam logic [4:0] ADD      = 5'b00000;
   localparam logic [4:0] ADDINC   = 5'b00001;
   localparam logic [4:0] INCA     = 5'b00011;
   localparam logic [4:0] SUBDEC   = 5'b00100;
   localparam logic [4:0] SUB      = 5'b00101;
   localparam logic [4:0] DECA     = 5'b00110;
   // Shifts
   localparam logic [4:0] LSL      = 5'b01000;
   localparam logic [4:0] ASR      = 5'b01001;
   // Logic
   localparam logic [4:0] ZEROS    = 5'b10000;
   localparam logic [4:0] AND      = 5'b10001;
   localparam logic [4:0] ANDNOTA  = 5'b10010;
   localparam logic [4:0] PASSB    = 5'b10011;
   localparam logic [4:0] ANDNOTB  = 5'b10100;
   localparam logic [4:0] PASSA    = 5'b10101;
   localparam logic [4:0] XOR      = 5'b10110;
   localparam logic [4:0] OR       = 5'b10111;
   localparam logic [4:0] NAND     = 5'b11000;
   localparam logic [4:0] XNOR     = 5'b11001;
   localparam logic [4:0] PASSNOTA = 5'b11010;
   localparam logic [4:0] ORNOTA   = 5'b11011;
   localparam logic [4:0] PASSNOTB = 5'b11100;
   localparam logic [4:0] ORNOTB   = 5'b11101;
   localparam logic [4:0] NOR      = 5'b11110;
   localparam logic [4:0] ONES     = 5'b11111;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the datapath and the ALU.
//   op[4:0]   opcode                 (master -> slave)
//   a, b      32-bit operands        (master -> slave)
//   res       registered result      (slave -> master)
//   o,s,c,z   registered flags       (slave -> master)
interface alu_if;
   import alu_pkg::*;

   logic [4:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] res;
   logic             o;
   logic             s;
   logic             c;
   logic             z;

   modport master (output op, a, b, input res, o, s, c, z);
   modport slave  (input op, a, b, output res, o, s, c, z);

endinterface

// File: rtl/alu_adder.sv
// alu_adder: 33-bit adder shared by every arithmetic opcode.
//   a, x   32-bit addends
//   cin    carry in
//   sum    low 32 bits of a + x + cin
//   cout   bit 32 of the sum
//   ovf    signed overflow (addends agree in sign, sum does not)
module alu_adder
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] x,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH:0] full;

   assign full = {1'b0, a} + {1'b0, x} + {{WIDTH{1'b0}}, cin};
   assign sum  = full[WIDTH-1:0];
   assign cout = full[WIDTH];
   assign ovf  = (a[WIDTH-1] == x[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// alu: registered 32-bit ALU, one cycle of latency, one op per cycle.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, clears result and flags
//   bus   alu_if.slave: op/a/b in, res and o/s/c/z flags out
// Optional feature macro ALU_SHIFT_EN: when defined, LSL and ASR are
// implemented; otherwise those opcodes decode as unlisted (res=0, z=1).
module alu
   import alu_pkg::*;
(
   input logic   clk,
   input logic   rst,
   alu_if.slave  bus
);

   logic [WIDTH-1:0] add_x;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic             add_ovf;

   logic [WIDTH-1:0] res_d, res_q;
   logic             o_d, c_d;
   logic [3:0]       flags_d, flags_q;

   // Second addend and carry-in for the shared adder
   always_comb begin
      add_x   = '0;
      add_cin = 1'b0;
      case (bus.op)
         ADD:     add_x = bus.b;
         ADDINC:  begin add_x = bus.b;  add_cin = 1'b1; end
         INCA:    add_cin = 1'b1;
         SUBDEC:  add_x = ~bus.b;
         SUB:     begin add_x = ~bus.b; add_cin = 1'b1; end
         DECA:    add_x = '1;
         default: ;
      endcase
   end

   alu_adder u_adder (
      .a    (bus.a),
      .x    (add_x),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout),
      .ovf  (add_ovf)
   );

   // Result mux; o/c stay 0 except for arithmetic and shifts
   always_comb begin
      res_d = '0;
      o_d   = 1'b0;
      c_d   = 1'b0;
      case (bus.op)
         ADD, ADDINC, INCA, SUBDEC, SUB, DECA: begin
            res_d = add_sum;
            c_d   = add_cout;
            o_d   = add_ovf;
         end
`ifdef ALU_SHIFT_EN
         LSL: begin
            res_d = {bus.a[WIDTH-2:0], 1'b0};
            c_d   = bus.a[WIDTH-1];
         end
         ASR: begin
            res_d = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
            c_d   = bus.a[0];
         end
`endif
         ZEROS:    res_d = '0;
         AND:      res_d = bus.a & bus.b;
         ANDNOTA:  res_d = ~bus.a & bus.b;
         PASSB:    res_d = bus.b;
         ANDNOTB:  res_d = bus.a & ~bus.b;
         PASSA:    res_d = bus.a;
         XOR:      res_d = bus.a ^ bus.b;
         OR:       res_d = bus.a | bus.b;
         NAND:     res_d = ~(bus.a & bus.b);
         XNOR:     res_d = ~(bus.a ^ bus.b);
         PASSNOTA: res_d = ~bus.a;
         ORNOTA:   res_d = ~bus.a | bus.b;
         PASSNOTB: res_d = ~bus.b;
         ORNOTB:   res_d = bus.a | ~bus.b;
         NOR:      res_d = ~(bus.a | bus.b);
         ONES:     res_d = '1;
         default:  res_d = '0;
      endcase
   end

   always_comb begin
      flags_d         = '0;
      flags_d[FLAG_O] = o_d;
      flags_d[FLAG_S] = res_d[WIDTH-1];
      flags_d[FLAG_C] = c_d;
      flags_d[FLAG_Z] = (res_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   assign bus.res = res_q;
   assign bus.o   = flags_q[FLAG_O];
   assign bus.s   = flags_q[FLAG_S];
   assign bus.c   = flags_q[FLAG_C];
   assign bus.z   = flags_q[FLAG_Z];

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu. Flags are compared packed as {o,s,c,z}.
module tb_alu;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   alu_if bus ();

   alu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h want %08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] flags();
      return {28'd0, bus.o, bus.s, bus.c, bus.z};
   endfunction

   task automatic check_out(input string tag, input logic [31:0] eres, input logic [3:0] efl);
      check({tag, " res"}, bus.res, eres);
      check({tag, " osczf"}, flags(), {28'd0, efl});
   endtask

   // Drive at negedge, sample 1 time unit after the capturing edge
   task automatic run(input string tag, input logic [4:0] op_v, input logic [31:0] a_v,
                      input logic [31:0] b_v, input logic [31:0] eres, input logic [3:0] efl);
      @(negedge clk);
      bus.op = op_v;
      bus.a  = a_v;
      bus.b  = b_v;
      @(posedge clk);
      #1;
      check_out(tag, eres, efl);
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      rst    = 1'b0;
      bus.op = ADD;
      bus.a  = 32'd0;
      bus.b  = 32'd0;
      #1 rst = 1'b1;
      #2 check_out("reset", 32'd0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;

      // Arithmetic
      run("add 1+2",        ADD,    32'd1,          32'd2, 32'd3,          4'b0000);
      // Inputs change between edges: output must hold
      @(negedge clk);
      bus.op = ONES;
      #1 check("hold res", bus.res, 32'd3);
      run("add ovf",        ADD,    32'h7FFF_FFFF,  32'd1, 32'h8000_0000,  4'b1100);
      run("add wrap",       ADD,    32'hFFFF_FFFF,  32'd1, 32'd0,          4'b0011);
      run("addinc",         ADDINC, 32'd1,          32'd2, 32'd4,          4'b0000);
      run("inca",           INCA,   32'd5,          32'd9, 32'd6,          4'b0000);
      run("sub 1-2",        SUB,    32'd1,          32'd2, 32'hFFFF_FFFF,  4'b0100);
      run("sub 5-5",        SUB,    32'd5,          32'd5, 32'd0,          4'b0011);
      run("subdec",         SUBDEC, 32'd5,          32'd2, 32'd2,          4'b0010);
      run("deca 0",         DECA,   32'd0,          32'd0, 32'hFFFF_FFFF,  4'b0100);

      // Shifts
`ifdef ALU_SHIFT_EN
      run("lsl",            LSL,    32'h8000_0001,  32'd0, 32'd2,          4'b0010);
      run("asr",            ASR,    32'h8000_0001,  32'd0, 32'hC000_0000,  4'b0110);
`else
      run("lsl off",        LSL,    32'h8000_0001,  32'd0, 32'd0,          4'b0001);
      run("asr off",        ASR,    32'h8000_0001,  32'd0, 32'd0,          4'b0001);
`endif

      // Logic, A=1 B=2
      run("zeros",          ZEROS,    32'd1, 32'd2, 32'd0,          4'b0001);
      run("and",            AND,      32'd1, 32'd2, 32'd0,          4'b0001);
      run("andnota",        ANDNOTA,  32'd1, 32'd2, 32'd2,          4'b0000);
      run("passb",          PASSB,    32'd1, 32'd2, 32'd2,          4'b0000);
      run("andnotb",        ANDNOTB,  32'd1, 32'd2, 32'd1,          4'b0000);
      run("passa",          PASSA,    32'd1, 32'd2, 32'd1,          4'b0000);
      run("xor",            XOR,      32'd1, 32'd2, 32'd3,          4'b0000);
      run("or",             OR,       32'd1, 32'd2, 32'd3,          4'b0000);
      run("nand",           NAND,     32'd1, 32'd2, 32'hFFFF_FFFF,  4'b0100);
      run("xnor",           XNOR,     32'd1, 32'd2, 32'hFFFF_FFFC,  4'b0100);
      run("passnota",       PASSNOTA, 32'd1, 32'd2, 32'hFFFF_FFFE,  4'b0100);
      run("ornota",         ORNOTA,   32'd1, 32'd2, 32'hFFFF_FFFE,  4'b0100);
      run("passnotb",       PASSNOTB, 32'd1, 32'd2, 32'hFFFF_FFFD,  4'b0100);
      run("ornotb",         ORNOTB,   32'd1, 32'd2, 32'hFFFF_FFFD,  4'b0100);
      run("nor",            NOR,      32'd1, 32'd2, 32'hFFFF_FFFC,  4'b0100);
      run("ones",           ONES,     32'd1, 32'd2, 32'hFFFF_FFFF,  4'b0100);

      // Unlisted opcodes
      run("op 00010",       5'b00010, 32'd1, 32'd2, 32'd0,          4'b0001);
      run("op 00111",       5'b00111, 32'hFFFF_FFFF, 32'd1, 32'd0,  4'b0001);
      run("op 01111",       5'b01111, 32'd1, 32'd2, 32'd0,          4'b0001);

      // Async reset between edges
      run("pre-rst ones",   ONES,     32'd0, 32'd0, 32'hFFFF_FFFF,  4'b0100);
      @(negedge clk);
      bus.op = ADD;
      bus.a  = 32'd1;
      bus.b  = 32'd2;
      #1 rst = 1'b1;
      #1 check_out("rst async", 32'd0, 4'b0000);
      @(posedge clk);
      #1 check_out("rst held", 32'd0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      #1 check_out("rst release", 32'd0, 4'b0000);
      @(posedge clk);
      #1 check_out("post-rst add", 32'd3, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
